// File: rtl/bch_encode_stream_pkg.sv
// Shared BCH definitions for the streaming encoder: FSM states and the
// generator-polynomial construction (product of minimal polynomials).
package bch_encode_stream_pkg;

    localparam int unsigned MAX_M   = 8;
    localparam int unsigned MAX_DEG = 127;

    typedef logic [MAX_DEG:0] poly_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ECC  = 2'd2
    } state_e;

    function automatic int unsigned bch_prim_poly(input int unsigned m);
        case (m)
            3:       return 32'h00B;
            4:       return 32'h013;
            5:       return 32'h025;
            6:       return 32'h043;
            7:       return 32'h089;
            8:       return 32'h11D;
            default: return 32'h000;
        endcase
    endfunction

    function automatic int unsigned gf_mul(input int unsigned a, input int unsigned b,
                                           input int unsigned m);
        int unsigned acc;
        int unsigned x;
        int unsigned prim;
        acc  = 32'd0;
        x    = a;
        prim = bch_prim_poly(m);
        for (int unsigned i = 0; i < m; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x << 1;
            if (x[m]) x = x ^ prim;
        end
        return acc;
    endfunction

    // g(x) = product of the minimal polynomials of alpha^1, alpha^3, ..., alpha^(2t-1)
    function automatic poly_t bch_gen_poly(input int unsigned m, input int unsigned t);
        int unsigned                 n;
        int unsigned                 j;
        int unsigned                 pw;
        int unsigned                 nk;
        logic [(MAX_M+1)*MAX_M-1:0]  mp;
        logic [255:0]                covered;
        poly_t                       g;
        poly_t                       mb;
        poly_t                       prod;
        logic                        done;
        n       = (32'd1 << m) - 32'd1;
        covered = '0;
        g       = poly_t'(1);
        for (int unsigned i = 1; i < 2 * t; i += 2) begin
            if (!covered[i]) begin
                mp    = '0;
                mp[0] = 1'b1;
                j     = i;
                done  = 1'b0;
                for (int unsigned c = 0; c < m; c++) begin
                    if (!done) begin
                        covered[j] = 1'b1;
                        pw = 32'd1;
                        for (int unsigned r = 0; r < j; r++) pw = gf_mul(pw, 32'd2, m);
                        for (int k = MAX_M; k >= 0; k--) begin
                            nk = gf_mul(32'(mp[k*MAX_M +: MAX_M]), pw, m);
                            if (k > 0) nk = nk ^ 32'(mp[(k-1)*MAX_M +: MAX_M]);
                            mp[k*MAX_M +: MAX_M] = MAX_M'(nk);
                        end
                        j    = (2 * j) % n;
                        done = (j == i);
                    end
                end
                mb = '0;
                for (int k = 0; k <= MAX_M; k++) mb[k] = mp[k*MAX_M];
                prod = '0;
                for (int k = 0; k <= MAX_DEG; k++) begin
                    if (mb[k]) prod = prod ^ (g << k);
                end
                g = prod;
            end
        end
        return g;
    endfunction

    function automatic int unsigned poly_degree(input poly_t p);
        int unsigned d;
        d = 32'd0;
        for (int unsigned k = 0; k <= MAX_DEG; k++) begin
            if (p[k]) d = k;
        end
        return d;
    endfunction

endpackage

// File: rtl/bch_encode_stream_if.sv
// Word-stream bus between the message source and the BCH encoder.
interface bch_encode_stream_if #(
    parameter int unsigned BITS = 1
);
    logic            ce;
    logic            start;
    logic [BITS-1:0] data_in;
    logic            ready;
    logic [BITS-1:0] data_out;
    logic            first;
    logic            last;
    logic            data_bits;
    logic            ecc_bits;

    modport master (
        output ce, start, data_in,
        input  ready, data_out, first, last, data_bits, ecc_bits
    );

    modport slave (
        input  ce, start, data_in,
        output ready, data_out, first, last, data_bits, ecc_bits
    );
endinterface

// File: rtl/bch_encode_stream_lfsr.sv
// Combinational BITS-step division of the parity LFSR by g(x), MSB of data first.
module bch_encode_lfsr_step #(
    parameter int unsigned   E    = 8,
    parameter int unsigned   BITS = 1,
    parameter logic [E-1:0]  G    = '0
) (
    input  logic [E-1:0]    lfsr_i,
    input  logic [BITS-1:0] data_i,
    output logic [E-1:0]    lfsr_c_o
);
    logic [E-1:0] s;

    always_comb begin
        s = lfsr_i;
        for (int b = BITS - 1; b >= 0; b--) begin
            if (s[E-1] ^ data_i[b]) s = (s << 1) ^ G;
            else                    s = s << 1;
        end
    end

    assign lfsr_c_o = s;
endmodule

// File: rtl/bch_encode_stream.sv
// Streaming systematic BCH encoder: passes K message bits through, then
// emits the E parity bits x^E*m(x) mod g(x), highest order first.
module bch_encode_stream
    import bch_encode_stream_pkg::*;
#(
    parameter int unsigned M    = 4,
    parameter int unsigned T    = 2,
    parameter int unsigned K    = 7,
    parameter int unsigned BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    bch_encode_stream_if.slave bus
);
    localparam poly_t       GEN     = bch_gen_poly(M, T);
    localparam int unsigned E       = poly_degree(GEN);
    localparam int unsigned DW      = K / BITS;
    localparam int unsigned EW      = E / BITS;
    localparam int unsigned CNT_MAX = (DW > EW) ? DW : EW;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [E-1:0] G_LOW  = GEN[E-1:0];

    // An unknown module name stops elaboration when BITS does not divide K and E
    if (((K % BITS) != 0) || ((E % BITS) != 0)) begin : g_bits_check
        bch_encode_stream_bits_must_divide_k_and_e u_bad ();
    end

    state_e          state_q, state_d;
    logic [E-1:0]    lfsr_q, lfsr_d;
    logic [E-1:0]    step_in, step_out;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] dout_q, dout_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic            dbits_q, dbits_d;
    logic            ebits_q, ebits_d;
    logic            ready_q, ready_d;

    // A start word always divides from a zero remainder
    assign step_in = ((state_q == ST_DATA) && !bus.start) ? lfsr_q : '0;

    bch_encode_lfsr_step #(
        .E    (E),
        .BITS (BITS),
        .G    (G_LOW)
    ) u_step (
        .lfsr_i   (step_in),
        .data_i   (bus.data_in),
        .lfsr_c_o (step_out)
    );

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        first_d = first_q;
        last_d  = last_q;
        dbits_d = dbits_q;
        ebits_d = ebits_q;
        if (bus.ce) begin
            case (state_q)
                ST_IDLE, ST_DATA: begin
                    if (bus.start || (state_q == ST_DATA)) begin
                        dout_d  = bus.data_in;
                        first_d = bus.start;
                        last_d  = 1'b0;
                        dbits_d = 1'b1;
                        ebits_d = 1'b0;
                        lfsr_d  = step_out;
                        if (bus.start) begin
                            if (DW == 1) begin
                                state_d = ST_ECC;
                                cnt_d   = '0;
                            end else begin
                                state_d = ST_DATA;
                                cnt_d   = CW'(1);
                            end
                        end else if (cnt_q == CW'(DW - 1)) begin
                            state_d = ST_ECC;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        first_d = 1'b0;
                        last_d  = 1'b0;
                        dbits_d = 1'b0;
                        ebits_d = 1'b0;
                    end
                end
                ST_ECC: begin
                    dout_d  = lfsr_q[E-1 -: BITS];
                    lfsr_d  = lfsr_q << BITS;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                    dbits_d = 1'b0;
                    ebits_d = 1'b1;
                    if (cnt_q == CW'(EW - 1)) begin
                        last_d  = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        lfsr_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        ready_d = (state_d != ST_ECC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            dbits_q <= 1'b0;
            ebits_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            first_q <= first_d;
            last_q  <= last_d;
            dbits_q <= dbits_d;
            ebits_q <= ebits_d;
            ready_q <= ready_d;
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.first     = first_q;
    assign bus.last      = last_q;
    assign bus.data_bits = dbits_q;
    assign bus.ecc_bits  = ebits_q;
    assign bus.ready     = ready_q;
endmodule
